// File: rtl/approx_add_pkg.sv
// approx_add_pkg: shared types and bit-level helpers for the pipelined
// lower-part-OR approximate adder.
//   beat_t       - one pipeline beat: valid, captured k, operands, partial
//                  sums and running carries of both the approximate and the
//                  exact chain. Fields are sized for the widest supported
//                  adder (32 bits); narrower instances leave the MSBs at 0.
//   seg_w()      - bits handled per pipeline stage (ceil(width/stages)).
//   exact_cell() - full adder, returns {carry, sum}.
//   approx_cell()- OR cell inside the approximate region, full adder above.
//   clamp_k()    - effective approximate LSB count for a new beat.
package approx_add_pkg;

    localparam int unsigned MAX_W = 32;
    localparam int unsigned K_W   = 5;

    typedef struct packed {
        logic             valid;
        logic [K_W-1:0]   k;
        logic [MAX_W-1:0] a;
        logic [MAX_W-1:0] b;
        logic [MAX_W-1:0] sum_ap;
        logic [MAX_W-1:0] sum_ex;
        logic             c_ap;
        logic             c_ex;
    } beat_t;

    function automatic int unsigned seg_w(input int unsigned width,
                                          input int unsigned stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic logic [1:0] exact_cell(input logic a, input logic b,
                                              input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Inside the approximate region the carry out is a&b. Only the topmost
    // approximate bit's carry is ever consumed (by bit k), which gives the
    // required carry-into-k = a[k-1]&b[k-1] and drops cin whenever k>0.
    function automatic logic [1:0] approx_cell(input logic a, input logic b,
                                               input logic c, input logic approx);
        return approx ? {a & b, a | b} : exact_cell(a, b, c);
    endfunction

    function automatic logic [K_W-1:0] clamp_k(input logic en,
                                               input logic [K_W-1:0] req,
                                               input int unsigned max_k);
        if (!en)
            return '0;
        if (32'(req) > max_k)
            return K_W'(max_k);
        return req;
    endfunction

endpackage

// File: rtl/approx_add_seg.sv
// approx_add_seg: one pipeline stage of the approximate adder. Adds segment
// IDX (bits IDX*SEG_W upward) of both the approximate and the exact chain,
// starting from the carries registered by the previous stage, and holds the
// result in its own register.
//   clk, rst  - clock, synchronous active-high reset
//   d         - incoming beat from the previous stage (or the input port)
//   d_ready   - this stage can take d on the next edge
//   q         - registered beat presented to the next stage
//   q_ready   - next stage (or downstream) takes q on the next edge
module approx_add_seg
    import approx_add_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned IDX    = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  beat_t d,
    output logic  d_ready,
    output beat_t q,
    input  logic  q_ready
);

    localparam int unsigned SEG_W = seg_w(WIDTH, STAGES);
    localparam int unsigned LO    = IDX * SEG_W;
    // One past the top bit; a trailing segment may be short or even empty.
    localparam int unsigned HI_EX = (LO + SEG_W > WIDTH) ? WIDTH : LO + SEG_W;

    beat_t nxt;
    logic  ca;
    logic  ce;

    always_comb begin
        nxt = d;
        ca  = d.c_ap;
        ce  = d.c_ex;
        for (int unsigned i = LO; i < HI_EX; i++) begin
            {ca, nxt.sum_ap[i]} = approx_cell(d.a[i], d.b[i], ca, i < 32'(d.k));
            {ce, nxt.sum_ex[i]} = exact_cell(d.a[i], d.b[i], ce);
        end
        nxt.c_ap = ca;
        nxt.c_ex = ce;
    end

    assign d_ready = !q.valid || q_ready;

    // Payload is only overwritten by a real beat so that the output data
    // stays put across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (d_ready) begin
            if (d.valid)
                q <= nxt;
            else
                q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/approx_add_pipe.sv
// approx_add_pipe: pipelined lower-part-OR approximate adder with an exact
// reference chain, per-result signed error and saturating statistics.
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - input handshake for a, b, cin, approx_en, approx_lsbs
//   approx_en         - 1 = approximate, 0 = exact
//   approx_lsbs       - requested approximate LSB count (clamped to APPROX_BITS)
//   out_valid/out_ready - output handshake for sum, cout, err
//   err               - exact minus approximate {cout,sum}, two's complement
//   stat_clr          - clears sample_cnt and mismatch_cnt
//   sample_cnt        - results delivered (saturating)
//   mismatch_cnt      - results delivered with err != 0 (saturating)
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 3,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     cin,
    input  logic                     approx_en,
    input  logic [$clog2(WIDTH)-1:0] approx_lsbs,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         sum,
    output logic                     cout,
    output logic [WIDTH+1:0]         err,
    input  logic                     stat_clr,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         mismatch_cnt
);

    beat_t head;
    beat_t pipe [STAGES];
    logic  rdy  [STAGES];
    beat_t last;

    always_comb begin
        head        = '0;
        head.valid  = in_valid;
        head.k      = clamp_k(approx_en, K_W'(approx_lsbs), APPROX_BITS);
        head.a      = MAX_W'(a);
        head.b      = MAX_W'(b);
        head.c_ap   = cin;
        head.c_ex   = cin;
    end

    for (genvar s = 0; s < int'(STAGES); s++) begin : g_seg
        beat_t d_in;
        logic  q_rdy;
        if (s == 0) begin : g_first
            assign d_in = head;
        end else begin : g_mid
            assign d_in = pipe[s-1];
        end
        if (s == int'(STAGES) - 1) begin : g_last
            assign q_rdy = out_ready;
        end else begin : g_inner
            assign q_rdy = rdy[s+1];
        end
        approx_add_seg #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (s)
        ) u_seg (
            .clk     (clk),
            .rst     (rst),
            .d       (d_in),
            .d_ready (rdy[s]),
            .q       (pipe[s]),
            .q_ready (q_rdy)
        );
    end

    assign in_ready = rdy[0];

    assign last      = pipe[STAGES-1];
    assign out_valid = last.valid;
    assign sum       = last.sum_ap[WIDTH-1:0];
    assign cout      = last.c_ap;
    assign err       = {1'b0, last.c_ex, last.sum_ex[WIDTH-1:0]}
                     - {1'b0, last.c_ap, last.sum_ap[WIDTH-1:0]};

    // Operands and k are spent by the last stage; only the result leaves.
    logic unused_bits;
    assign unused_bits = ^{last.k, last.a, last.b, last.sum_ap, last.sum_ex};

    logic fire;
    assign fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
        end else if (fire) begin
            if (sample_cnt != '1)
                sample_cnt <= sample_cnt + CNT_W'(1);
            if (err != '0 && mismatch_cnt != '1)
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/approx_add_pipe.md
Name: approx_add_pipe

Overview:
Parametrised, pipelined lower-part-OR approximate adder for the Laplace filter datapath. It generalises the fixed 8-bit approximate ripple adder in three ways: width is parametrised, the number of approximate LSBs is selectable at run time, and the carry chain is segmented across pipeline stages behind a valid/ready handshake. An exact reference chain runs alongside the approximate one, so every result carries its signed error, and saturating counters record error statistics.

Parameters:
WIDTH, 8, operand/sum width (4..32)
APPROX_BITS, 3, maximum approximate LSB count (0..WIDTH-1)
STAGES, 2, pipeline register stages (1..4, STAGES <= WIDTH)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry in
approx_en  in  1  1 = approximate mode, 0 = exact
approx_lsbs  in  $clog2(WIDTH)  requested approximate LSB count
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  approximate (or exact) sum
cout  out  1  carry out
err  out  WIDTH+2  signed, exact minus approximate {cout,sum}
stat_clr  in  1  clear statistics counters
sample_cnt  out  CNT_W  results delivered
mismatch_cnt  out  CNT_W  results delivered with err != 0

Behaviour:
- Effective k = approx_en ? min(approx_lsbs, APPROX_BITS) : 0. k is captured with the operands on acceptance and travels with the beat, so a config change never alters beats already in flight.
- Approximate arithmetic:
  - bits i<k: sum[i] = a[i] | b[i].
  - Carry into bit k = a[k-1] & b[k-1]; cin is ignored when k>0.
  - Bits i>=k use an exact full-adder ripple.
  - k=0 gives the exact a+b+cin.
- Exact chain: always computes a+b+cin. err = {1'b0,cout_exact,sum_exact} - {1'b0,cout,sum}, two's complement. err may be negative.
- Segmentation:
  - WIDTH is split into STAGES segments of ceil(WIDTH/STAGES) bits, LSB segment first; the last segment may be shorter.
  - Stage s adds segment s of both chains, using the carries registered by stage s-1.
  - Unprocessed operand bits and finished sum bits are forwarded with the beat.
- Handshake:
  - Elastic pipeline with one register per stage.
  - A stage advances when it is empty or the next stage advances.
  - in_ready = !stage0_valid | stage0_advance.
  - A beat is accepted on in_valid & in_ready.
  - out_valid / sum / cout / err come from the last stage and hold stable while out_valid & !out_ready.
  - Latency is STAGES cycles from acceptance to out_valid with out_ready held high. Throughput is 1 beat/cycle. Order is preserved and no beat is dropped or duplicated.
- Statistics:
  - On out_valid & out_ready, sample_cnt increments; mismatch_cnt also increments if err != 0.
  - Both counters saturate at all-ones.
  - stat_clr zeroes both on the next edge and wins over a simultaneous increment; that event is not counted.
- Reset:
  - All stage valids, sum, cout, err and both counters go to 0 on the first edge with rst=1.
  - Beats in flight are discarded.
  - in_ready = 1 from the first cycle after reset deasserts.
  - rst overrides stat_clr and the handshake.

Decomposition:
- Package approx_add_pkg:
  - SEG_W = (WIDTH+STAGES-1)/STAGES.
  - Beat struct: valid, k, remaining operands, partial sums, both carries.
  - Functions approx_cell() and exact_cell().
  - k clamp function.
- Sub-module approx_add_seg: one segment adder plus its pipeline register and valid/ready logic, instantiated STAGES times by a generate loop.

Test Plan:
1. Exact mode: approx_en=0, a=0xF0, b=0x1F, cin=1 -> after 2 cycles sum=0x10, cout=1, err=0, sample_cnt=1, mismatch_cnt=0.
2. k=3: a=0x07, b=0x01, cin=0 -> sum=0x07, cout=0, err=+1, mismatch_cnt=1.
3. k=3: a=0x0C, b=0x04 -> sum=0x14, err=-4 (0x3FC in 10 bits).
4. Clamp: approx_lsbs=5 with APPROX_BITS=3, case-2 operands -> identical results to case 2. Change approx_en mid-stream -> in-flight beats use their captured k.
5. Backpressure: 4 back-to-back beats, out_ready=0 for 3 cycles -> in_ready falls after 2 beats held; all 4 results later emerge in order, stable while stalled.
6. rst asserted with 2 beats in flight plus stat_clr -> next cycle out_valid=0 and counters=0. Then drive 2^CNT_W+1 mismatching results with CNT_W=4 -> mismatch_cnt saturates at 15.
